mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the registered ALU result (effective address or plain result), the store source, and the decoded memory opcode.
- Runs a request/acknowledge transaction to data memory for loads and stores. Non-memory results pass straight through.
- Produces the writeback bundle and a hold signal that stalls the execute buffer while a transaction is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ACK_TIMEOUT, 255, number of REQ cycles without an ack before an access fault is raised; must be ≥1.
- CNT_W, $clog2(ACK_TIMEOUT+1), width of the timeout counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute stage presents a valid instruction.
- EXE_Result  in  XLEN  ALU result; this is the effective address for memory ops.
- Store_src  in  XLEN  store data, LSB-aligned.
- mem_op  in  5  [4] is_mem, [3] is_store, [2] unsigned load, [1:0] size (00 byte, 01 half, 10 word).
- rd_in  in  5  destination register.
- wb_en_in  in  1  instruction writes rd.
- MEMHold  out  1  stall request to the execute buffer.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  XLEN  word-aligned address.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_wstrb  out  4  byte strobes.
- dmem_ack  in  1  request completion; read data is valid in the same cycle.
- dmem_rdata  in  XLEN  read word.
- wb_valid  out  1  writeback bundle valid; one-cycle pulse per instruction.
- wb_en  out  1  register write enable.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  writeback data.
- misalign_fault  out  1  one-cycle pulse with wb_valid.
- access_fault  out  1  one-cycle pulse with wb_valid.

Behaviour:
- Reset (async, rst=1) applies to every output and to internal state:
  - All outputs and the counter clear to 0.
  - FSM goes to IDLE.
  - dmem_req drops immediately, even mid-transaction.
  - No writeback is emitted for an aborted op.
- FSM states are IDLE and REQ.
- MEMHold = (state==REQ), decoded directly from the state register.
- Accept condition: in_valid & ~MEMHold. Cycles where in_valid=0 produce wb_valid=0.
- Non-memory op (mem_op[4]=0): at the accept edge, wb_valid=1, wb_en=wb_en_in, wb_rd=rd_in, wb_data=EXE_Result. Latency is 1 cycle and the FSM stays in IDLE.
- Misalignment is checked at accept. Half with addr[0]=1, or word with addr[1:0]≠0, gives:
  - no request;
  - next cycle wb_valid=1, wb_en=0, misalign_fault=1;
  - FSM stays in IDLE.
- Aligned memory op:
  - At the accept edge, register dmem_addr={addr[XLEN-1:2],2'b00}, dmem_we=mem_op[3], the strobes and the wdata. Latch rd, size and sign. Go to REQ and clear the counter.
  - Store strobes: byte uses 4'b0001<<addr[1:0]; half uses 4'b0011<<addr[1:0]; word uses 4'b1111.
  - wdata: a byte is replicated into all four lanes; a half is replicated into both halves.
- REQ state:
  - dmem_req=1. Address, we, wstrb and wdata are held stable until ack.
  - On dmem_ack: next cycle wb_valid=1 and state returns to IDLE.
    - Load: wb_en=latched wb_en, wb_data=formatted read.
    - Store: wb_en=0.
  - Without ack: the counter increments. When it equals ACK_TIMEOUT-1 (i.e. on the ACK_TIMEOUT-th REQ cycle with no ack), the next cycle gives wb_valid=1, wb_en=0, access_fault=1, and the FSM returns to IDLE.
  - If ack and timeout coincide in the same cycle, ack wins.
- Load formatting:
  - Select the lane by addr[1:0].
  - Byte: sign-extend bit 7, or zero-extend if unsigned.
  - Half: lane 0 or 2, extend from bit 15.
  - Word: pass through unchanged.
- Throughput: back-to-back non-memory ops run 1 per cycle. A memory op costs at least 2 cycles of MEMHold low-to-low: one REQ cycle, then one IDLE bubble.
- dmem_ack is ignored while in IDLE.

Decomposition:
- Package mem_pkg holds:
  - mem_op bit-position constants;
  - size codes BYTE/HALF/WORD;
  - the FSM state encoding (IDLE=0, REQ=1).
- One combinational sub-module, load_align, takes rdata, offset, size and unsigned, and returns the extended XLEN result. It is reused by the verification reference model.

Test Plan:
- Non-mem op, EXE_Result=0x1234_5678, rd_in=5, wb_en_in=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x12345678, MEMHold stays 0.
- Signed LB, address 0x103, ack after 3 REQ cycles, rdata=0x80FF_0000 -> dmem_addr=0x100 and req held for 3 cycles, then wb_data=0xFFFF_FF80. The same access with the unsigned bit set gives 0x0000_0080.
- SH, address 0x202, Store_src=0x0000_ABCD -> wstrb=4'b1100, wdata=0xABCD_ABCD, dmem_we=1; after ack wb_valid=1 with wb_en=0.
- LW at address 0x301 -> dmem_req never asserted; next cycle misalign_fault=1, wb_valid=1, wb_en=0.
- ACK_TIMEOUT=4, no ack -> dmem_req high for exactly 4 cycles, then access_fault pulse and MEMHold low. A repeat with ack on the 4th cycle gives a normal completion and no fault.
- rst asserted during REQ -> dmem_req and MEMHold drop asynchronously and no wb_valid is emitted. After release, an immediate non-mem op completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared opcode bit positions, size codes and FSM encoding for the memory access stage
package mem_pkg;
  localparam int MOP_MEM   = 4;
  localparam int MOP_STORE = 3;
  localparam int MOP_UNS   = 2;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} size_e;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed lane of a read word and sign/zero-extends it
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  size_e           size,
  input  logic            uns,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    data = size == BYTE ? {{(XLEN-8){~uns & b[7]}}, b}
         : size == HALF ? {{(XLEN-16){~uns & h[15]}}, h}
         : rdata;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: runs req/ack data-memory transactions for loads/stores and forms the writeback bundle
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] EXE_Result,
  input  logic [XLEN-1:0] Store_src,
  input  logic [4:0]      mem_op,
  input  logic [4:0]      rd_in,
  input  logic            wb_en_in,
  output logic            MEMHold,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_fault,
  output logic            access_fault
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d, ld_data;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [4:0]        rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [1:0]        off_q, off_d;
  size_e             size_q, size_d;
  logic              we_q, we_d, wben_q, wben_d, uns_q, uns_d;
  logic              wb_valid_q, wb_valid_d, wb_en_q, wb_en_d, mis_q, mis_d, acc_q, acc_d;
  logic              accept, is_mem, misal, go, timeout, done, ackd;
  logic [1:0]        off;
  assign off     = EXE_Result[1:0];
  assign accept  = in_valid & (state_q == IDLE);
  assign is_mem  = mem_op[MOP_MEM];
  // size 2'b11 is treated like a word access
  assign misal   = mem_op[1] ? |off : mem_op[0] & off[0];
  assign go      = accept & is_mem & ~misal;
  assign timeout = cnt_q == CNT_W'(ACK_TIMEOUT - 1);
  assign ackd    = (state_q == REQ) & dmem_ack;
  assign done    = (state_q == REQ) & (dmem_ack | timeout);
  load_align #(.XLEN(XLEN)) u_align (
    .rdata(dmem_rdata), .off(off_q), .size(size_q), .uns(uns_q), .data(ld_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      wben_q     <= 1'b0;
      off_q      <= '0;
      size_q     <= BYTE;
      uns_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      acc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      wben_q     <= wben_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
      acc_q      <= acc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && go) state_d = REQ;
    else if (done) state_d = IDLE;
  end
  always_comb begin
    cnt_d      = go ? '0 : (state_q == REQ) ? cnt_q + CNT_W'(1) : cnt_q;
    addr_d     = go ? {EXE_Result[XLEN-1:2], 2'b00} : addr_q;
    we_d       = go ? mem_op[MOP_STORE] : we_q;
    wstrb_d    = go ? (mem_op[1] ? 4'b1111 : mem_op[0] ? 4'b0011 << off : 4'b0001 << off) : wstrb_q;
    wdata_d    = go ? (mem_op[1] ? Store_src : mem_op[0] ? {2{Store_src[15:0]}} : {4{Store_src[7:0]}}) : wdata_q;
    rd_d       = go ? rd_in : rd_q;
    wben_d     = go ? wb_en_in : wben_q;
    off_d      = go ? off : off_q;
    size_d     = go ? size_e'(mem_op[1:0]) : size_q;
    uns_d      = go ? mem_op[MOP_UNS] : uns_q;
    wb_valid_d = (accept & (~is_mem | misal)) | done;
    wb_en_d    = (accept & ~is_mem) ? wb_en_in : ackd & ~we_q & wben_q;
    wb_rd_d    = accept ? rd_in : done ? rd_q : wb_rd_q;
    wb_data_d  = (accept & ~is_mem) ? EXE_Result : ackd ? ld_data : wb_data_q;
    mis_d      = accept & is_mem & misal;
    acc_d      = (state_q == REQ) & ~dmem_ack & timeout;
  end
  assign MEMHold        = state_q == REQ;
  assign dmem_req       = state_q == REQ;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_wstrb     = wstrb_q;
  assign wb_valid       = wb_valid_q;
  assign wb_en          = wb_en_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign misalign_fault = mis_q;
  assign access_fault   = acc_q;
endmodule
